// File: rtl/cpu_pkg.sv
// Shared core definitions: halt-instruction encodings, halt cause codes and
// the retire/halt monitor state encoding.
package cpu_pkg;

    localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK   = 32'h0010_0073;
    localparam logic [31:0] INSTR_JAL_SELF = 32'h0000_006F;

    typedef enum logic [1:0] {
        HALT_NONE      = 2'd0,
        HALT_ECALL     = 2'd1,
        HALT_EBREAK    = 2'd2,
        HALT_SELF_LOOP = 2'd3
    } halt_cause_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } halt_mon_state_e;

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter with enable and asynchronous clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (en && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/retire_halt_monitor.sv
// Watches the retire stream for ECALL / EBREAK / jal x0,0, drains the
// pipeline, then raises a sticky cpu_finish; a watchdog forces finish.
module retire_halt_monitor
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned DRAIN_CYCLES    = 4,
    parameter int unsigned WATCHDOG_CYCLES = 5000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            retire_valid,
    input  logic [XLEN-1:0] retire_pc,
    input  logic [31:0]     retire_instr,
    output logic            cpu_finish,
    output logic            timeout,
    output logic [1:0]      halt_cause,
    output logic [XLEN-1:0] halt_pc,
    output logic [XLEN-1:0] cycle_count,
    output logic [XLEN-1:0] instret_count
);

    localparam bit              NO_DRAIN   = (DRAIN_CYCLES == 0);
    localparam bit              WD_ENABLE  = (WATCHDOG_CYCLES != 0);
    localparam logic [31:0]     DRAIN_LOAD = 32'(DRAIN_CYCLES - 1);
    localparam logic [XLEN-1:0] WD_LAST    = XLEN'(WATCHDOG_CYCLES - 1);

    halt_mon_state_e state, state_nxt;
    halt_cause_e     halt_code, halt_cause_q;
    logic [31:0]     drain_cnt;
    logic [XLEN-1:0] last_pc;
    logic            halt_hit, wd_expire;
    logic            cyc_en, ret_en;

    // Decode is gated by retire_valid so an undriven instr bus cannot leak in.
    always_comb begin
        halt_code = HALT_NONE;
        if (retire_valid) begin
            case (retire_instr)
                INSTR_ECALL:    halt_code = HALT_ECALL;
                INSTR_EBREAK:   halt_code = HALT_EBREAK;
                INSTR_JAL_SELF: halt_code = HALT_SELF_LOOP;
                default:        halt_code = HALT_NONE;
            endcase
        end
    end

    assign halt_hit  = (halt_code != HALT_NONE);
    assign wd_expire = WD_ENABLE && (cycle_count == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            cpu_finish <= 1'b0;
        end else begin
            state      <= state_nxt;
            cpu_finish <= (state_nxt == ST_DONE) || (state_nxt == ST_TIMEOUT);
        end
    end

    // Halt takes priority over a coincident watchdog expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (halt_hit)
                    state_nxt = NO_DRAIN ? ST_DONE : ST_DRAIN;
                else if (wd_expire)
                    state_nxt = ST_TIMEOUT;
            end
            ST_DRAIN: begin
                if (drain_cnt == '0)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        cyc_en = (state == ST_RUN) || (state == ST_DRAIN);
        ret_en = (state == ST_RUN) && retire_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt    <= '0;
            last_pc      <= '0;
            halt_pc      <= '0;
            halt_cause_q <= HALT_NONE;
            timeout      <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (retire_valid)
                        last_pc <= retire_pc;
                    if (halt_hit) begin
                        halt_pc      <= retire_pc;
                        halt_cause_q <= halt_code;
                        drain_cnt    <= DRAIN_LOAD;
                    end else if (wd_expire) begin
                        timeout      <= 1'b1;
                        halt_cause_q <= HALT_NONE;
                        halt_pc      <= retire_valid ? retire_pc : last_pc;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt != '0)
                        drain_cnt <= drain_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign halt_cause = halt_cause_q;

    sat_counter #(.WIDTH(XLEN)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cyc_en),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(XLEN)) u_instret_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (ret_en),
        .count (instret_count)
    );

endmodule

// File: tb/tb_retire_halt_monitor.sv
// Directed bench for retire_halt_monitor: three instances with different
// drain/watchdog settings share one retire stream and reset.
module tb_retire_halt_monitor;

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] JALSLF = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        reset;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_instr;

    logic        a_fin, a_to, b_fin, b_to, c_fin, c_to;
    logic [1:0]  a_cause, b_cause, c_cause;
    logic [31:0] a_hpc, a_cyc, a_ret, b_hpc, b_cyc, b_ret, c_hpc, c_cyc, c_ret;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    retire_halt_monitor #(.XLEN(32), .DRAIN_CYCLES(4), .WATCHDOG_CYCLES(5000)) dut_a (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_instr(retire_instr), .cpu_finish(a_fin), .timeout(a_to),
        .halt_cause(a_cause), .halt_pc(a_hpc), .cycle_count(a_cyc), .instret_count(a_ret)
    );

    retire_halt_monitor #(.XLEN(32), .DRAIN_CYCLES(0), .WATCHDOG_CYCLES(5000)) dut_b (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_instr(retire_instr), .cpu_finish(b_fin), .timeout(b_to),
        .halt_cause(b_cause), .halt_pc(b_hpc), .cycle_count(b_cyc), .instret_count(b_ret)
    );

    retire_halt_monitor #(.XLEN(32), .DRAIN_CYCLES(4), .WATCHDOG_CYCLES(20)) dut_c (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_instr(retire_instr), .cpu_finish(c_fin), .timeout(c_to),
        .halt_cause(c_cause), .halt_pc(c_hpc), .cycle_count(c_cyc), .instret_count(c_ret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one retire slot, then land 1 time unit after the sampling edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        retire_valid = v;
        retire_pc    = pc;
        retire_instr = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'hx);
    endtask

    task automatic do_reset();
        retire_valid = 1'b0;
        retire_pc    = '0;
        retire_instr = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        retire_valid = 1'b0;
        retire_pc    = '0;
        retire_instr = '0;
        #12;

        // reset state
        check("rst_finish",  {31'd0, a_fin}, 32'd0);
        check("rst_timeout", {31'd0, a_to},  32'd0);
        check("rst_cause",   {30'd0, a_cause}, 32'd0);
        check("rst_hpc",     a_hpc, 32'd0);
        check("rst_cyc",     a_cyc, 32'd0);
        check("rst_ret",     a_ret, 32'd0);
        do_reset();

        // ECALL after three ADDIs, drain of 4
        step(1'b1, 32'h04, ADDI);
        step(1'b1, 32'h08, ADDI);
        step(1'b1, 32'h0C, ADDI);
        step(1'b1, 32'h10, ECALL);
        check("ecall_fin_t0", {31'd0, a_fin}, 32'd0);
        check("ecall_cause",  {30'd0, a_cause}, 32'd1);
        check("ecall_hpc",    a_hpc, 32'h10);
        idle(); idle(); idle();
        check("ecall_fin_t3", {31'd0, a_fin}, 32'd0);
        idle();
        check("ecall_fin_t4", {31'd0, a_fin}, 32'd1);
        check("ecall_ret",    a_ret, 32'd4);
        check("ecall_to",     {31'd0, a_to}, 32'd0);
        check("ecall_cyc",    a_cyc, 32'd8);
        step(1'b1, 32'h80, ADDI);
        step(1'b1, 32'h84, EBREAK);
        check("done_cyc_frozen", a_cyc, 32'd8);
        check("done_ret_frozen", a_ret, 32'd4);
        check("done_cause_held", {30'd0, a_cause}, 32'd1);

        // EBREAK with zero drain
        do_reset();
        step(1'b1, 32'h20, EBREAK);
        check("ebreak_fin",   {31'd0, b_fin}, 32'd1);
        check("ebreak_cause", {30'd0, b_cause}, 32'd2);
        check("ebreak_hpc",   b_hpc, 32'h20);
        check("ebreak_ret",   b_ret, 32'd1);
        check("ebreak_cyc",   b_cyc, 32'd1);

        // self-loop keeps retiring during drain
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h40, JALSLF);
        check("loop_fin_t3", {31'd0, a_fin}, 32'd0);
        check("loop_ret_t3", a_ret, 32'd1);
        step(1'b1, 32'h40, JALSLF);
        check("loop_fin",   {31'd0, a_fin}, 32'd1);
        check("loop_ret",   a_ret, 32'd1);
        check("loop_hpc",   a_hpc, 32'h40);
        check("loop_cause", {30'd0, a_cause}, 32'd3);

        // watchdog of 20, valid toggling, X instr on idle slots
        do_reset();
        for (int i = 0; i < 19; i++) begin
            if (i % 2 == 0) step(1'b1, 32'h100 + 32'(4 * i), ADDI);
            else            step(1'b0, 32'h100 + 32'(4 * i), 32'hx);
        end
        check("wd_fin_19", {31'd0, c_fin}, 32'd0);
        step(1'b0, 32'h100 + 32'(4 * 19), 32'hx);
        check("wd_fin",   {31'd0, c_fin}, 32'd1);
        check("wd_to",    {31'd0, c_to}, 32'd1);
        check("wd_cause", {30'd0, c_cause}, 32'd0);
        check("wd_cyc",   c_cyc, 32'd20);
        check("wd_hpc",   c_hpc, 32'h148);
        check("wd_ret",   c_ret, 32'd10);
        idle();
        check("wd_cyc_frozen", c_cyc, 32'd20);

        // ECALL exactly on the watchdog edge
        do_reset();
        for (int i = 0; i < 19; i++) step(1'b1, 32'h300 + 32'(4 * i), ADDI);
        step(1'b1, 32'h200, ECALL);
        check("race_to_t0",  {31'd0, c_to}, 32'd0);
        check("race_fin_t0", {31'd0, c_fin}, 32'd0);
        idle(); idle(); idle(); idle();
        check("race_fin",   {31'd0, c_fin}, 32'd1);
        check("race_to",    {31'd0, c_to}, 32'd0);
        check("race_cause", {30'd0, c_cause}, 32'd1);
        check("race_hpc",   c_hpc, 32'h200);
        check("race_ret",   c_ret, 32'd20);
        check("race_cyc",   c_cyc, 32'd24);

        // reset two cycles into drain, then a clean ECALL
        do_reset();
        step(1'b1, 32'h10, ECALL);
        idle(); idle();
        reset = 1'b1;
        #1;
        check("mrst_fin",   {31'd0, a_fin}, 32'd0);
        check("mrst_cause", {30'd0, a_cause}, 32'd0);
        check("mrst_hpc",   a_hpc, 32'd0);
        check("mrst_cyc",   a_cyc, 32'd0);
        check("mrst_ret",   a_ret, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 32'h30, ECALL);
        idle(); idle(); idle();
        check("mrst2_fin_t3", {31'd0, a_fin}, 32'd0);
        idle();
        check("mrst2_fin",   {31'd0, a_fin}, 32'd1);
        check("mrst2_cause", {30'd0, a_cause}, 32'd1);
        check("mrst2_hpc",   a_hpc, 32'h30);
        check("mrst2_ret",   a_ret, 32'd1);
        check("mrst2_cyc",   a_cyc, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
